hilo_muldiv_ctrl: RTL and testbench

- Owns the architectural HI/LO register pair and sequences every HI/LO-writing operation issued from the EX stage: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- Multiplies complete in one cycle. Divides run on an iterative radix-2 core for 32 iterations, with a pipeline stall.
- hi_out/lo_out feed the ALU's HiInput/LoInput for MFHI/MFLO.

---
 rtl/hilo_muldiv_pkg.sv | 28 ++
 rtl/hilo_muldiv_ctrl_div_radix2.sv | 81 ++++++++
 rtl/hilo_muldiv_ctrl.sv | 166 ++++++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/hilo_muldiv_pkg.sv
// -----------------------------------------------------------------------------
// hilo_muldiv_pkg
// Shared definitions for the HI/LO multiply/divide controller: EX-stage
// operation codes for the HI/LO-writing instructions, the divider FSM state
// encoding, and a small op-decode helper.
// -----------------------------------------------------------------------------
package hilo_muldiv_pkg;

  localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  // Divider sequencing states (2-bit codes).
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic is_div_op(input logic [7:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_div_radix2.sv
// -----------------------------------------------------------------------------
// div_radix2
// Unsigned restoring radix-2 divider: one shift-subtract step per cycle for
// WIDTH cycles after start. Operands are magnitudes; sign handling lives in
// the caller.
//   clk, rst     : clock, synchronous active-high reset
//   i_start      : load operands and begin iterating
//   i_abort      : drop an in-flight divide
//   i_dividend   : dividend magnitude
//   i_divisor    : divisor magnitude (nonzero; zero is handled by the caller)
//   o_quotient   : quotient, valid the cycle after o_done
//   o_remainder  : remainder, valid the cycle after o_done
//   o_done       : high during the final iteration cycle
// -----------------------------------------------------------------------------
module div_radix2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dsr;
  logic [CW-1:0]    r_cnt;
  logic             r_run;

  // Partial remainder shifted left by one with the next dividend bit brought
  // in; one extra bit so the trial subtraction's borrow is visible.
  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_diff;

  assign w_shifted = {r_rem, r_quo[WIDTH-1]};
  assign w_diff    = w_shifted - {1'b0, r_dsr};

  assign o_done      = r_run && (r_cnt == CW'(WIDTH - 1));
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register sees the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_run <= 1'b0;
      r_cnt <= '0;
      r_rem <= '0;
      r_quo <= '0;
      r_dsr <= '0;
    end else if (i_abort) begin
      r_run <= 1'b0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_run <= 1'b1;
      r_cnt <= '0;
      r_rem <= '0;
      r_quo <= i_dividend;
      r_dsr <= i_divisor;
    end else if (r_run) begin
      // Quotient bits shift in where dividend bits shift out.
      if (!w_diff[WIDTH]) begin
        r_rem <= w_diff[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
      end else begin
        r_rem <= w_shifted[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
      end
      r_cnt <= r_cnt + 1'b1;
      if (o_done) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// hilo_muldiv_ctrl
// Owns the HI/LO register pair and sequences MULT/MULTU (single cycle),
// DIV/DIVU (iterative, stalls the pipeline) and MTHI/MTLO.
//   clk, rst        : clock, synchronous active-high reset
//   op              : EX-stage operation code
//   a, b            : rs / rt operands
//   en              : EX instruction valid and not otherwise stalled
//   flush           : EX instruction annulled
//   hi_out, lo_out  : committed HI / LO
//   stall           : hold IF..EX (combinational)
//   busy            : divider FSM not idle (registered state)
// -----------------------------------------------------------------------------
module hilo_muldiv_ctrl
  import hilo_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             en,
  input  logic             flush,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             stall,
  output logic             busy
);

  div_state_e r_state, w_state_nxt;

  logic [WIDTH-1:0] r_hi, r_lo;
  logic [WIDTH-1:0] r_a_raw;
  logic             r_qsign, r_rsign, r_dbz;

  logic             w_issue, w_div_issue, w_signed_div, w_dbz, w_start;
  logic [WIDTH-1:0] w_abs_a, w_abs_b;
  logic [WIDTH-1:0] w_core_quo, w_core_rem, w_quo_fix, w_rem_fix;
  logic             w_core_done;
  logic [2*WIDTH-1:0] w_prod_s, w_prod_u;
  logic             w_hi_we, w_lo_we;
  logic [WIDTH-1:0] w_hi_nxt, w_lo_nxt;

  assign w_issue      = en && !flush && (r_state == DIV_IDLE);
  assign w_div_issue  = w_issue && is_div_op(op);
  assign w_signed_div = (op == EXE_DIV_OP);
  assign w_dbz        = (b == '0);
  assign w_start      = w_div_issue && !w_dbz;

  assign w_abs_a = (w_signed_div && a[WIDTH-1]) ? -a : a;
  assign w_abs_b = (w_signed_div && b[WIDTH-1]) ? -b : b;

  // Full-width products via explicit sign/zero extension to 2*WIDTH.
  assign w_prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign w_prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  assign w_quo_fix = r_qsign ? -w_core_quo : w_core_quo;
  assign w_rem_fix = r_rsign ? -w_core_rem : w_core_rem;

  div_radix2 #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_start),
    .i_abort    (flush),
    .i_dividend (w_abs_a),
    .i_divisor  (w_abs_b),
    .o_quotient (w_core_quo),
    .o_remainder(w_core_rem),
    .o_done     (w_core_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= DIV_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  // NOTE: every always_comb output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      DIV_IDLE: if (w_div_issue) w_state_nxt = w_dbz ? DIV_DONE : DIV_BUSY;
      DIV_BUSY: begin
        if (flush)            w_state_nxt = DIV_IDLE;
        else if (w_core_done) w_state_nxt = DIV_DONE;
      end
      DIV_DONE: w_state_nxt = DIV_IDLE;
      default:  w_state_nxt = DIV_IDLE;
    endcase
  end

  // Output logic: stall and the single HI/LO write source for this cycle.
  always_comb begin
    stall    = 1'b0;
    w_hi_we  = 1'b0;
    w_lo_we  = 1'b0;
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    unique case (r_state)
      DIV_IDLE: begin
        if (w_issue) begin
          case (op)
            EXE_MULT_OP: begin
              w_hi_we = 1'b1; w_lo_we = 1'b1;
              {w_hi_nxt, w_lo_nxt} = w_prod_s;
            end
            EXE_MULTU_OP: begin
              w_hi_we = 1'b1; w_lo_we = 1'b1;
              {w_hi_nxt, w_lo_nxt} = w_prod_u;
            end
            EXE_MTHI_OP: begin
              w_hi_we = 1'b1; w_hi_nxt = a;
            end
            EXE_MTLO_OP: begin
              w_lo_we = 1'b1; w_lo_nxt = a;
            end
            EXE_DIV_OP, EXE_DIVU_OP: stall = 1'b1;
            default: ;
          endcase
        end
      end
      DIV_BUSY: stall = !flush;
      DIV_DONE: begin
        // The held DIV is still on op/en here; state != IDLE keeps it from
        // restarting, and stall=0 lets the pipeline advance past it.
        if (!flush) begin
          w_hi_we  = 1'b1;
          w_lo_we  = 1'b1;
          w_hi_nxt = r_dbz ? r_a_raw : w_rem_fix;
          w_lo_nxt = r_dbz ? '1      : w_quo_fix;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (w_hi_we) r_hi <= w_hi_nxt;
      if (w_lo_we) r_lo <= w_lo_nxt;
    end
  end

  // NOTE: these divide-context registers carry no reset: they are only read
  // in DIV_DONE, which is always entered through an issue that loads them.
  always_ff @(posedge clk) begin
    if (w_div_issue) begin
      r_a_raw <= a;
      r_dbz   <= w_dbz;
      r_qsign <= w_signed_div && (a[WIDTH-1] ^ b[WIDTH-1]);
      r_rsign <= w_signed_div && a[WIDTH-1];
    end
  end

  assign hi_out = r_hi;
  assign lo_out = r_lo;
  assign busy   = (r_state != DIV_IDLE);

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hilo_muldiv_ctrl
// Directed self-checking bench for hilo_muldiv_ctrl. Inputs change 1 time unit
// after a rising edge; outputs are sampled 1 time unit after inputs settle.
// -----------------------------------------------------------------------------
module tb_hilo_muldiv_ctrl;
  import hilo_muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   op;
  logic [W-1:0] a, b;
  logic         en, flush;
  logic [W-1:0] hi_out, lo_out;
  logic         stall, busy;

  int n_tests = 0;
  int n_fail  = 0;

  hilo_muldiv_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .op    (op),
    .a     (a),
    .b     (b),
    .en    (en),
    .flush (flush),
    .hi_out(hi_out),
    .lo_out(lo_out),
    .stall (stall),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds a divide on op/en until stall drops (the DONE cycle), lets the DONE
  // edge commit, then retires the instruction. Loop is bounded; a timeout
  // shows up as a wrong stall count.
  task automatic run_div(input logic [7:0] d_op, input logic [W-1:0] d_a,
                         input logic [W-1:0] d_b, output int sc, output int bc);
    sc = 0;
    bc = 0;
    op = d_op; a = d_a; b = d_b; en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (busy) bc++;
      if (!stall) break;
      sc++;
      tick();
    end
    tick();
    en = 1'b0; op = EXE_NOP_OP;
    #1;
  endtask

  int sc, bc;

  initial begin
    rst = 1'b1; op = EXE_NOP_OP; a = '0; b = '0; en = 1'b0; flush = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("reset_hi", hi_out, 32'h0);
    check("reset_lo", lo_out, 32'h0);
    check("reset_stall", {31'b0, stall}, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);

    // MULT -2 * 3 = -6
    op = EXE_MULT_OP; a = 32'hFFFF_FFFE; b = 32'd3; en = 1'b1;
    #1;
    check("mult_stall", {31'b0, stall}, 32'h0);
    tick();
    op = EXE_MULTU_OP;
    #1;
    check("mult_hi", hi_out, 32'hFFFF_FFFF);
    check("mult_lo", lo_out, 32'hFFFF_FFFA);
    check("multu_stall", {31'b0, stall}, 32'h0);
    tick();
    en = 1'b0; op = EXE_NOP_OP;
    #1;
    check("multu_hi", hi_out, 32'h0000_0002);
    check("multu_lo", lo_out, 32'hFFFF_FFFA);

    // DIV -7 / 2 = -3 rem -1
    run_div(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, sc, bc);
    check("div_stall_cycles", sc, 32'd33);
    check("div_busy_cycles", bc, 32'd33);
    check("div_lo", lo_out, 32'hFFFF_FFFD);
    check("div_hi", hi_out, 32'hFFFF_FFFF);
    check("div_busy_after", {31'b0, busy}, 32'h0);

    // DIVU 100 / 7 = 14 rem 2
    run_div(EXE_DIVU_OP, 32'd100, 32'd7, sc, bc);
    check("divu_stall_cycles", sc, 32'd33);
    check("divu_lo", lo_out, 32'd14);
    check("divu_hi", hi_out, 32'd2);

    // Signed overflow: 0x80000000 / -1
    run_div(EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, sc, bc);
    check("ovf_lo", lo_out, 32'h8000_0000);
    check("ovf_hi", hi_out, 32'h0);

    // Signed divide with negative divisor: 20 / -6 = -3 rem 2
    run_div(EXE_DIV_OP, 32'd20, 32'hFFFF_FFFA, sc, bc);
    check("negdsr_lo", lo_out, 32'hFFFF_FFFD);
    check("negdsr_hi", hi_out, 32'd2);

    // DIVU by zero
    run_div(EXE_DIVU_OP, 32'd5, 32'd0, sc, bc);
    check("dbz_stall_cycles", sc, 32'd1);
    check("dbz_busy_cycles", bc, 32'd1);
    check("dbz_lo", lo_out, 32'hFFFF_FFFF);
    check("dbz_hi", hi_out, 32'd5);

    // Flush on BUSY cycle 10; en dropped mid-divide must not stop iterating
    op = EXE_DIV_OP; a = 32'd100; b = 32'd3; en = 1'b1;
    tick();
    en = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("flush_pre_busy", {31'b0, busy}, 32'h1);
    check("flush_pre_stall", {31'b0, stall}, 32'h1);
    en = 1'b1; flush = 1'b1;
    #1;
    check("flush_stall", {31'b0, stall}, 32'h0);
    tick();
    flush = 1'b0; en = 1'b0; op = EXE_NOP_OP;
    #1;
    check("flush_busy", {31'b0, busy}, 32'h0);
    check("flush_hi_kept", hi_out, 32'd5);
    check("flush_lo_kept", lo_out, 32'hFFFF_FFFF);
    run_div(EXE_DIVU_OP, 32'd1000, 32'd9, sc, bc);
    check("post_flush_stall", sc, 32'd33);
    check("post_flush_lo", lo_out, 32'd111);
    check("post_flush_hi", hi_out, 32'd1);

    // MTHI then MTLO back to back
    op = EXE_MTHI_OP; a = 32'h1234_5678; en = 1'b1;
    tick();
    op = EXE_MTLO_OP; a = 32'h9ABC_DEF0;
    #1;
    check("mthi_hi", hi_out, 32'h1234_5678);
    check("mthi_lo_kept", lo_out, 32'd111);
    tick();
    en = 1'b0; op = EXE_NOP_OP;
    #1;
    check("mtlo_hi_kept", hi_out, 32'h1234_5678);
    check("mtlo_lo", lo_out, 32'h9ABC_DEF0);

    // Reset on BUSY cycle 20
    op = EXE_DIV_OP; a = 32'd50; b = 32'd7; en = 1'b1;
    tick();
    for (int i = 0; i < 19; i++) tick();
    check("rst_pre_busy", {31'b0, busy}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b0; op = EXE_NOP_OP;
    #1;
    check("rst_mid_hi", hi_out, 32'h0);
    check("rst_mid_lo", lo_out, 32'h0);
    check("rst_mid_busy", {31'b0, busy}, 32'h0);
    check("rst_mid_stall", {31'b0, stall}, 32'h0);

    // MTLO annulled by flush
    op = EXE_MTLO_OP; a = 32'hDEAD_BEEF; en = 1'b1; flush = 1'b1;
    tick();
    en = 1'b0; flush = 1'b0; op = EXE_NOP_OP;
    #1;
    check("flushed_mtlo_lo", lo_out, 32'h0);

    // Flushed DIV issue must not start the divider
    op = EXE_DIV_OP; a = 32'd9; b = 32'd3; en = 1'b1; flush = 1'b1;
    #1;
    check("flushed_div_stall", {31'b0, stall}, 32'h0);
    tick();
    en = 1'b0; flush = 1'b0; op = EXE_NOP_OP;
    #1;
    check("flushed_div_busy", {31'b0, busy}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
